ysyx_23060332_ifu: RTL and testbench

Instruction fetch unit between the PC stage and the decode path of the core top. It accepts a fetch address from the PC stage and runs a request/grant/response transaction on the instruction memory port. It registers the returned word and presents it to decode with a valid/ready handshake, replacing the current raw `inst` input. It also handles redirect flushes, misaligned PCs, bus errors and response timeouts, so decode never sees a stale or missing instruction.

---
 rtl/ysyx_23060332_ifu.sv | 88 ++++++++
 tb/tb_ysyx_23060332_ifu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// ysyx_23060332_ifu: instruction fetch unit with request/grant/response memory port and valid/ready decode handoff
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pc_i/pc_valid_i/pc_ready_o fetch address handshake from the PC stage
//   flush_i                   redirect; kills the in-flight fetch
//   mem_req_o/mem_addr_o/mem_gnt_i             memory request channel
//   mem_rvalid_i/mem_rdata_i/mem_err_i         memory response channel
//   inst_valid_o/inst_ready_i/inst_o/inst_addr_o/inst_fault_o  decode handoff
module ysyx_23060332_ifu #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  input  logic              mem_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_fault_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  state_t            state_q;
  logic              drop_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic              fault_q;
  logic              wait_done;
  // the transaction ends on a response or on the last allowed wait cycle
  assign wait_done    = mem_rvalid_i || cnt_q == CNT_LAST;
  assign pc_ready_o   = state_q == IDLE;
  assign mem_req_o    = state_q == REQ;
  assign mem_addr_o   = addr_q;
  assign inst_valid_o = state_q == HOLD;
  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign inst_fault_o = fault_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pc_valid_i && !flush_i) begin
          addr_q <= pc_i;
          if (|pc_i[1:0]) begin
            state_q <= HOLD;
            fault_q <= 1'b1;
            inst_q  <= NOP_INST;
          end else state_q <= REQ;
        end
        REQ: if (mem_gnt_i) begin
          state_q <= WAIT;
          cnt_q   <= '0;
          drop_q  <= flush_i;
        end else if (flush_i) state_q <= IDLE;
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (wait_done) begin
            // a flush in the completing cycle drops the result just like an earlier one
            state_q <= (drop_q || flush_i) ? IDLE : HOLD;
            drop_q  <= 1'b0;
            fault_q <= !mem_rvalid_i || mem_err_i;
            inst_q  <= (mem_rvalid_i && !mem_err_i) ? mem_rdata_i : NOP_INST;
          end else drop_q <= drop_q || flush_i;
        end
        default: if (flush_i || inst_ready_i) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// tb_ysyx_23060332_ifu: table-driven and directed checks of the instruction fetch unit
module tb_ysyx_23060332_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_fault_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  localparam logic [31:0] NOP = 32'h00000013;

  ysyx_23060332_ifu #(.ADDR_W(32), .INST_W(32), .TIMEOUT(8), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .inst_fault_o(inst_fault_o)
  );

  always #5 clk = ~clk;

  // st: expected phase of the cycle, 0 idle, 1 request, 2 waiting, 3 presenting
  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl, gnt, rv;
    logic [31:0] rd;
    logic        err, rdy;
    int          st;
    logic [31:0] a, inst;
    logic        flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic pv, logic [31:0] pc, logic fl, logic gnt, logic rv,
                             logic [31:0] rd, logic err, logic rdy, int st,
                             logic [31:0] a, logic [31:0] inst, logic flt);
    vec_t r;
    r.pv = pv; r.pc = pc; r.fl = fl; r.gnt = gnt; r.rv = rv; r.rd = rd; r.err = err;
    r.rdy = rdy; r.st = st; r.a = a; r.inst = inst; r.flt = flt;
    return r;
  endfunction

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // basic fetch
    tbl.push_back(v(1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80000000, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h00100093, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h80000000, 32'h00100093, 0));
    // grant stall: five refused cycles then a grant
    tbl.push_back(v(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80000004, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80000004, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h00200113, 0, 0, 2, 0, 0, 0));
    // backpressure for four cycles
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h80000004, 32'h00200113, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h80000004, 32'h00200113, 0));
    // flush in WAIT, late response dropped
    tbl.push_back(v(1, 32'h80000008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80000008, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80000004, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h00300193, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h80000004, 32'h00300193, 0));
    // misaligned pc: presented next cycle, no request
    tbl.push_back(v(1, 32'h80000002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h80000002, NOP, 1));
    // bus error
    tbl.push_back(v(1, 32'h8000000C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h8000000C, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h12345678, 1, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h8000000C, NOP, 1));
    // flush in HOLD beats ready, flush in IDLE blocks pc_valid
    tbl.push_back(v(1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h80000010, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hAAAA5555, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 3, 32'h80000010, 32'hAAAA5555, 0));
    tbl.push_back(v(1, 32'h80000020, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // flush in REQ without grant withdraws the request
    tbl.push_back(v(1, 32'h80000014, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80000014, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step();
    step();
    cmp("reset pc_ready", pc_ready_o, 1);
    cmp("reset mem_req", mem_req_o, 0);
    cmp("reset inst_valid", inst_valid_o, 0);
    cmp("reset fault", inst_fault_o, 0);
    cmp("reset mem_addr", mem_addr_o, 0);
    cmp("reset inst", inst_o, 0);
    cmp("reset inst_addr", inst_addr_o, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      pc_valid_i = tbl[i].pv; pc_i = tbl[i].pc; flush_i = tbl[i].fl; mem_gnt_i = tbl[i].gnt;
      mem_rvalid_i = tbl[i].rv; mem_rdata_i = tbl[i].rd; mem_err_i = tbl[i].err;
      inst_ready_i = tbl[i].rdy;
      cmp($sformatf("v%0d pc_ready", i), pc_ready_o, tbl[i].st == 0);
      cmp($sformatf("v%0d mem_req", i), mem_req_o, tbl[i].st == 1);
      cmp($sformatf("v%0d inst_valid", i), inst_valid_o, tbl[i].st == 3);
      if (tbl[i].st == 1) cmp($sformatf("v%0d mem_addr", i), mem_addr_o, tbl[i].a);
      if (tbl[i].st == 3) begin
        cmp($sformatf("v%0d inst", i), inst_o, tbl[i].inst);
        cmp($sformatf("v%0d inst_addr", i), inst_addr_o, tbl[i].a);
        cmp($sformatf("v%0d fault", i), inst_fault_o, tbl[i].flt);
      end
      step();
    end
    pc_valid_i = 0; flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; inst_ready_i = 0;

    // timeout: fault presented 8 cycles after entering WAIT, late response ignored
    pc_valid_i = 1; pc_i = 32'h80000018;
    step();
    pc_valid_i = 0; mem_gnt_i = 1;
    cmp("to req", mem_req_o, 1);
    step();
    mem_gnt_i = 0;
    for (int k = 0; k < 8; k++) begin
      cmp($sformatf("to wait%0d valid", k), inst_valid_o, 0);
      cmp($sformatf("to wait%0d req", k), mem_req_o, 0);
      step();
    end
    cmp("to valid", inst_valid_o, 1);
    cmp("to fault", inst_fault_o, 1);
    cmp("to inst", inst_o, NOP);
    cmp("to inst_addr", inst_addr_o, 32'h80000018);
    mem_rvalid_i = 1; mem_rdata_i = 32'h00000055;
    step();
    mem_rvalid_i = 0;
    cmp("late valid", inst_valid_o, 1);
    cmp("late inst", inst_o, NOP);
    cmp("late fault", inst_fault_o, 1);
    inst_ready_i = 1;
    step();
    inst_ready_i = 0;
    cmp("to idle", pc_ready_o, 1);

    // reset during WAIT aborts immediately; response after release ignored
    pc_valid_i = 1; pc_i = 32'h8000001C;
    step();
    pc_valid_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    cmp("rw in wait", pc_ready_o, 0);
    rst = 1;
    #1;
    cmp("rw pc_ready", pc_ready_o, 1);
    cmp("rw mem_req", mem_req_o, 0);
    cmp("rw valid", inst_valid_o, 0);
    cmp("rw fault", inst_fault_o, 0);
    cmp("rw mem_addr", mem_addr_o, 0);
    cmp("rw inst", inst_o, 0);
    cmp("rw inst_addr", inst_addr_o, 0);
    step();
    rst = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h00000077;
    step();
    mem_rvalid_i = 0;
    cmp("post rst valid", inst_valid_o, 0);
    cmp("post rst pc_ready", pc_ready_o, 1);
    step();
    cmp("post rst valid2", inst_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
